hwag_coil_bank: RTL

//  Multi-channel ignition output stage driven by the HWAG master angle counter (ACNT).

---
 rtl/hwag_coil_bank.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/hwag_coil_bank.sv
// hwag_coil_bank: multi-channel ignition coil driver slaved to the HWAG master angle counter.
// Latency: coil/fault/busy/err are registered; they change one clk after the step or request.
// Backpressure: upd_req is a pulse taken only while upd_busy=0; a request while busy is dropped.
module hwag_coil_bank #(
  parameter int CH_NUM     = 4,
  parameter int ACNT_WIDTH = 24,
  parameter int ACR_MAX    = 3839,
  parameter int DWELL_W    = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hwag_start,
  input  logic                         acnt_step,
  input  logic [ACNT_WIDTH-1:0]        acnt_in,
  input  logic [CH_NUM*ACNT_WIDTH-1:0] ch_phase,
  input  logic [CH_NUM-1:0]            ch_ena,
  input  logic [CH_NUM*ACNT_WIDTH-1:0] set_angle_in,
  input  logic [CH_NUM*ACNT_WIDTH-1:0] reset_angle_in,
  input  logic [DWELL_W-1:0]           dwell_max,
  input  logic                         upd_req,
  output logic                         upd_busy,
  output logic                         upd_err,
  output logic [CH_NUM-1:0]            coil_out,
  output logic [CH_NUM-1:0]            fault_out
);

  // One extra bit so acnt + phase cannot overflow before the wrap correction.
  localparam int AW = ACNT_WIDTH + 1;
  localparam logic [AW-1:0]         ANG_MAX    = AW'(ACR_MAX);
  localparam logic [AW-1:0]         ANG_PERIOD = AW'(ACR_MAX + 1);
  localparam logic [ACNT_WIDTH-1:0] REQ_MAX    = ACNT_WIDTH'(ACR_MAX);
  localparam logic [DWELL_W-1:0]    DWELL_SAT  = '1;

  typedef logic [CH_NUM-1:0][ACNT_WIDTH-1:0] ang_vec_t;

  // Per-channel views of the flat angle buses.
  ang_vec_t phase_v, set_req_v, rst_req_v;
  assign phase_v   = ch_phase;
  assign set_req_v = set_angle_in;
  assign rst_req_v = reset_angle_in;

  ang_vec_t set_act_q, set_act_d, rst_act_q, rst_act_d;
  ang_vec_t set_pend_q, set_pend_d, rst_pend_q, rst_pend_d;
  logic [CH_NUM-1:0][DWELL_W-1:0] dwell_q, dwell_d;
  logic [CH_NUM-1:0] coil_q, coil_d, fault_q, fault_d, pend_q, pend_d;
  logic upd_busy_q, upd_busy_d, upd_err_q, upd_err_d;

  logic [CH_NUM-1:0][AW-1:0] ch_ang;
  logic [CH_NUM-1:0] evt, set_hit, rst_hit, trip;
  logic range_bad, upd_take;

  // Master angle plus channel phase, folded back into 0..ACR_MAX with a single subtract.
  function automatic logic [AW-1:0] wrap_ang(input logic [ACNT_WIDTH-1:0] a,
                                             input logic [ACNT_WIDTH-1:0] p);
    logic [AW-1:0] sum;
    sum = {1'b0, a} + {1'b0, p};
    return (sum > ANG_MAX) ? (sum - ANG_PERIOD) : sum;
  endfunction

  // Per-channel angle, event strobes and watchdog expiry.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      ch_ang[i]  = wrap_ang(acnt_in, phase_v[i]);
      evt[i]     = acnt_step & hwag_start & ch_ena[i];
      set_hit[i] = evt[i] & (ch_ang[i] == {1'b0, set_act_q[i]});
      rst_hit[i] = evt[i] & (ch_ang[i] == {1'b0, rst_act_q[i]});
      trip[i]    = hwag_start & ch_ena[i] & coil_q[i] &
                   (dwell_max != '0) & (dwell_q[i] >= dwell_max);
    end
  end

  // Request validation: any enabled channel with an out-of-cycle angle rejects the whole load.
  always_comb begin
    range_bad = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_ena[i] && ((set_req_v[i] > REQ_MAX) || (rst_req_v[i] > REQ_MAX))) begin
        range_bad = 1'b1;
      end
    end
    upd_take  = upd_req & ~upd_busy_q & ~range_bad;
    upd_err_d = upd_req & ~upd_busy_q & range_bad;
  end

  // Next state: capture, coil drive, watchdog and the glitch-free apply of pending angles.
  always_comb begin
    set_act_d  = set_act_q;
    rst_act_d  = rst_act_q;
    set_pend_d = set_pend_q;
    rst_pend_d = rst_pend_q;
    pend_d     = pend_q;
    fault_d    = fault_q;
    coil_d     = coil_q;
    dwell_d    = dwell_q;

    // busy is low here, so no channel is pending and capture cannot collide with an apply.
    if (upd_take) begin
      set_pend_d = set_req_v;
      rst_pend_d = rst_req_v;
      pend_d     = ch_ena;
      fault_d    = '0;
    end

    for (int i = 0; i < CH_NUM; i++) begin
      // Stop/disable dominates; a reset event or watchdog expiry beats a set event.
      if (!hwag_start || !ch_ena[i]) begin
        coil_d[i] = 1'b0;
      end else if (rst_hit[i] || trip[i]) begin
        coil_d[i] = 1'b0;
      end else if (set_hit[i]) begin
        coil_d[i] = 1'b1;
      end

      if (trip[i]) begin
        fault_d[i] = 1'b1;
      end

      // Counts clks spent on; any off clk restarts it from zero.
      if (coil_q[i] && coil_d[i]) begin
        dwell_d[i] = (dwell_q[i] == DWELL_SAT) ? DWELL_SAT : dwell_q[i] + DWELL_W'(1);
      end else begin
        dwell_d[i] = '0;
      end

      // Swap in new angles only where the output cannot glitch: at a spark, or idle at angle 0.
      if (!ch_ena[i]) begin
        pend_d[i] = 1'b0;
      end else if (evt[i] && pend_q[i] &&
                   ((!coil_d[i] && (ch_ang[i] == '0)) || rst_hit[i])) begin
        set_act_d[i] = set_pend_q[i];
        rst_act_d[i] = rst_pend_q[i];
        pend_d[i]    = 1'b0;
      end
    end

    upd_busy_d = |pend_d;
  end

  // State registers; reset drops every coil and aborts any pending load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_act_q  <= '0;
      rst_act_q  <= '0;
      set_pend_q <= '0;
      rst_pend_q <= '0;
      pend_q     <= '0;
      fault_q    <= '0;
      coil_q     <= '0;
      dwell_q    <= '0;
      upd_busy_q <= 1'b0;
      upd_err_q  <= 1'b0;
    end else begin
      set_act_q  <= set_act_d;
      rst_act_q  <= rst_act_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      pend_q     <= pend_d;
      fault_q    <= fault_d;
      coil_q     <= coil_d;
      dwell_q    <= dwell_d;
      upd_busy_q <= upd_busy_d;
      upd_err_q  <= upd_err_d;
    end
  end

  assign coil_out  = coil_q;
  assign fault_out = fault_q;
  assign upd_busy  = upd_busy_q;
  assign upd_err   = upd_err_q;

endmodule
